motor_pwm_ramp_driver: RTL

//   Downstream stage of the partial-ramp start FSM. Consumes its one-hot speed levels
//   (30 %, 50 %, 100 %) and drives a single motor PWM line. The duty cycle slews toward
//   the commanded level in fixed steps, one step per PWM period, so every speed change
//   is glitch-free. Illegal multi-hot commands latch a fault that forces the output off.

---
 rtl/motor_pwm_ramp_driver.sv | 113 +++++++++++
 1 files changed

// File: rtl/motor_pwm_ramp_driver.sv
// Single-line motor PWM driver: decodes one-hot speed levels, slews the duty cycle
// one bounded step per PWM period and latches a fault on multi-hot commands.
module motor_pwm_ramp_driver #(
    parameter int PERIOD = 100,
    parameter int STEP   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       lvl_30,
    input  logic       lvl_50,
    input  logic       lvl_100,
    input  logic       clr_fault,
    output logic       pwm_out,
    output logic [6:0] duty,
    output logic       at_target,
    output logic       fault
);

    localparam logic [6:0] PER  = 7'(PERIOD);
    localparam logic [6:0] LAST = 7'(PERIOD - 1);
    localparam logic [6:0] STP  = 7'(STEP);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RAMP,
        ST_HOLD,
        ST_FAULT
    } state_t;

    state_t     state;
    logic [6:0] cnt;
    logic [6:0] target;
    logic [6:0] next_duty;
    logic       illegal;
    logic       boundary;

    function automatic logic [6:0] clamp_period(input logic [6:0] v);
        return (v > PER) ? PER : v;
    endfunction

    // Move toward target by at most STP; subtract only after comparing, so no underflow.
    function automatic logic [6:0] step_toward(input logic [6:0] cur, input logic [6:0] tgt);
        logic [6:0] res;
        res = cur;
        if (cur < tgt)
            res = ((tgt - cur) > STP) ? cur + STP : tgt;
        else if (cur > tgt)
            res = ((cur - tgt) > STP) ? cur - STP : tgt;
        return res;
    endfunction

    function automatic state_t classify(input logic [6:0] d, input logic [6:0] tgt);
        state_t s;
        if (d != tgt)
            s = ST_RAMP;
        else if (tgt == 7'd0)
            s = ST_IDLE;
        else
            s = ST_HOLD;
        return s;
    endfunction

    always_comb begin
        illegal = (lvl_30 & lvl_50) | (lvl_30 & lvl_100) | (lvl_50 & lvl_100);
        target  = 7'd0;
        if (!illegal) begin
            if (lvl_30)
                target = clamp_period(7'd30);
            else if (lvl_50)
                target = clamp_period(7'd50);
            else if (lvl_100)
                target = clamp_period(7'd100);
        end
        boundary  = en && (cnt == LAST);
        next_duty = boundary ? step_toward(duty, target) : duty;
    end

    assign at_target = (duty == target) && !fault;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= 7'd0;
            duty    <= 7'd0;
            pwm_out <= 1'b0;
            fault   <= 1'b0;
            state   <= ST_IDLE;
        end else if (illegal) begin
            cnt     <= 7'd0;
            duty    <= 7'd0;
            pwm_out <= 1'b0;
            fault   <= 1'b1;
            state   <= ST_FAULT;
        end else if (state == ST_FAULT) begin
            // Output stays parked at zero; a legal command plus clear restarts from IDLE.
            cnt     <= 7'd0;
            duty    <= 7'd0;
            pwm_out <= 1'b0;
            if (clr_fault) begin
                fault <= 1'b0;
                state <= ST_IDLE;
            end
        end else begin
            if (en) begin
                cnt     <= (cnt == LAST) ? 7'd0 : cnt + 7'd1;
                pwm_out <= (cnt < duty);
                duty    <= next_duty;
            end
            state <= classify(next_duty, target);
        end
    end

endmodule
